// File: rtl/irq_cfg_pkg.sv
// Shared definitions for the irq_router configuration path: loader FSM states,
// routing-entry field layout and the entry-count helper used by the router side.
package irq_cfg_pkg;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        WRITE  = 2'd2,
        RELOAD = 2'd3
    } cfg_state_e;

    // Routing entry layout: bit7 enables the route, [3:0] selects the target cpu.
    localparam int ENTRY_W       = 8;
    localparam int ENTRY_EN_BIT  = 7;
    localparam int ENTRY_CPU_LSB = 0;
    localparam int ENTRY_CPU_W   = 4;

    // Maskable entries (one per slot and channel) followed by one NMI entry per slot.
    function automatic int calc_num_entries(input int num_slots, input int num_ch);
        return num_slots * num_ch + num_slots;
    endfunction

endpackage

// File: rtl/irq_cfg_shadow.sv
// Shadow copy of the irq_router routing table. The router cannot be read back
// from this side, so every entry written to it is mirrored here.
// One write port, one registered read port; out-of-range reads return zero.
module irq_cfg_shadow
    import irq_cfg_pkg::*;
#(
    parameter int                 DEPTH      = 9,
    parameter int                 ADDR_W     = 8,
    parameter logic [ENTRY_W-1:0] INIT_VALUE = '0
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic               rd_en,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [ENTRY_W-1:0] rd_data
);

    localparam int               IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic               wr_hit;
    logic               rd_hit;

    assign wr_hit = wr_en && (wr_addr < DEPTH_A);
    assign rd_hit = rd_addr < DEPTH_A;

    // Entry storage: comes out of reset holding the default routing value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= INIT_VALUE;
            end
        end else if (wr_hit) begin
            mem[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    // Registered read: a read on the same edge as a write sees the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_hit ? mem[rd_addr[IDX_W-1:0]] : '0;
        end
    end

endmodule

// File: rtl/irq_cfg_loader.sv
// Owner of the irq_router configuration port. After reset it writes
// DEFAULT_ENTRY into every routing entry, then forwards host writes one at a
// time and keeps a readable shadow of the table. The router's cfg_rd_en is
// tied low at the dock level; nothing here reads the router.
// Optional build macro IRQ_CFG_LOCK_EN adds a sticky lock that drops host
// writes and reload requests until the next reset.
module irq_cfg_loader
    import irq_cfg_pkg::*;
#(
    parameter int                 NUM_SLOTS       = 3,
    parameter int                 NUM_TILE_INT_CH = 2,
    parameter int                 CFG_ADDR_WIDTH  = 8,
    parameter logic [ENTRY_W-1:0] DEFAULT_ENTRY   = 8'h00
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      host_wr_valid,
    output logic                      host_wr_ready,
    input  logic [CFG_ADDR_WIDTH-1:0] host_wr_addr,
    input  logic [ENTRY_W-1:0]        host_wr_data,
    input  logic                      host_rd_en,
    input  logic [CFG_ADDR_WIDTH-1:0] host_rd_addr,
    output logic [ENTRY_W-1:0]        host_rd_data,
    input  logic                      reload_req,
    input  logic                      lock_set,
    output logic                      busy,
    output logic                      addr_err,
    output logic                      cfg_wr_en,
    output logic [CFG_ADDR_WIDTH-1:0] cfg_addr,
    output logic [ENTRY_W-1:0]        cfg_wdata
);

    localparam int                        N        = calc_num_entries(NUM_SLOTS, NUM_TILE_INT_CH);
    localparam logic [CFG_ADDR_WIDTH-1:0] N_A      = CFG_ADDR_WIDTH'(N);
    localparam logic [CFG_ADDR_WIDTH-1:0] LAST_IDX = CFG_ADDR_WIDTH'(N - 1);

    cfg_state_e                state;
    logic [CFG_ADDR_WIDTH-1:0] idx;
    logic                      reload_pend;
    logic                      locked;

    logic                      fill_active;
    logic                      accept;
    logic                      addr_ok;
    logic                      wr_commit;
    logic                      reload_go;

    logic                      sh_we;
    logic [CFG_ADDR_WIDTH-1:0] sh_waddr;
    logic [ENTRY_W-1:0]        sh_wdata;

`ifdef IRQ_CFG_LOCK_EN
    logic lock_q;

    // Sticky lock: armed from IDLE, only reset releases it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= 1'b0;
        end else if ((state == IDLE) && lock_set) begin
            lock_q <= 1'b1;
        end
    end

    assign locked = lock_q;
`else
    logic unused_lock_set;

    assign unused_lock_set = lock_set;
    assign locked          = 1'b0;
`endif

    // Handshake decode and shadow write-port steering for fill passes vs host writes.
    always_comb begin
        fill_active = (state == INIT) || (state == RELOAD);
        accept      = (state == IDLE) && host_wr_valid && host_wr_ready;
        addr_ok     = host_wr_addr < N_A;
        wr_commit   = accept && addr_ok && !locked;
        reload_go   = (reload_pend || reload_req) && !locked;
        sh_we       = fill_active || wr_commit;
        sh_waddr    = fill_active ? idx : host_wr_addr;
        sh_wdata    = fill_active ? DEFAULT_ENTRY : host_wr_data;
    end

    // Main sequencer: default fill, host write forwarding, reload scheduling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= INIT;
            idx           <= '0;
            reload_pend   <= 1'b0;
            cfg_wr_en     <= 1'b0;
            cfg_addr      <= '0;
            cfg_wdata     <= '0;
            host_wr_ready <= 1'b0;
            busy          <= 1'b1;
            addr_err      <= 1'b0;
        end else begin
            cfg_wr_en <= 1'b0;
            case (state)
                INIT, RELOAD: begin
                    cfg_wr_en     <= 1'b1;
                    cfg_addr      <= idx;
                    cfg_wdata     <= DEFAULT_ENTRY;
                    busy          <= 1'b1;
                    host_wr_ready <= 1'b0;
                    reload_pend   <= 1'b0;
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        state <= IDLE;
                    end else begin
                        idx <= idx + CFG_ADDR_WIDTH'(1);
                    end
                end
                IDLE: begin
                    if (wr_commit) begin
                        cfg_wr_en     <= 1'b1;
                        cfg_addr      <= host_wr_addr;
                        cfg_wdata     <= host_wr_data;
                        host_wr_ready <= 1'b0;
                        busy          <= 1'b0;
                        reload_pend   <= reload_req;
                        state         <= WRITE;
                    end else begin
                        if (accept) begin
                            addr_err <= 1'b1;
                        end
                        if (reload_go) begin
                            idx           <= '0;
                            host_wr_ready <= 1'b0;
                            busy          <= 1'b1;
                            reload_pend   <= 1'b0;
                            state         <= RELOAD;
                        end else begin
                            host_wr_ready <= 1'b1;
                            busy          <= 1'b0;
                        end
                    end
                end
                WRITE: begin
                    if (reload_go) begin
                        idx           <= '0;
                        host_wr_ready <= 1'b0;
                        busy          <= 1'b1;
                        reload_pend   <= 1'b0;
                        state         <= RELOAD;
                    end else begin
                        host_wr_ready <= 1'b1;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= INIT;
                    idx   <= '0;
                end
            endcase
        end
    end

    irq_cfg_shadow #(
        .DEPTH      (N),
        .ADDR_W     (CFG_ADDR_WIDTH),
        .INIT_VALUE (DEFAULT_ENTRY)
    ) u_shadow (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (sh_we),
        .wr_addr (sh_waddr),
        .wr_data (sh_wdata),
        .rd_en   (host_rd_en),
        .rd_addr (host_rd_addr),
        .rd_data (host_rd_data)
    );

endmodule
